// File: rtl/proc_arb_pkg.sv
// Shared types and default sizing for the proc round-robin arbiter.
package proc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } arb_state_t;

  localparam int unsigned PROC_N_REQ    = 4;
  localparam int unsigned PROC_MAX_HOLD = 8;

endpackage

// File: rtl/proc_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or after ptr_i wins.
module proc_rr_pick import proc_arb_pkg::*; #(
  parameter int unsigned N_REQ = PROC_N_REQ,
  parameter int unsigned SelW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [SelW-1:0]  ptr_i,
  output logic [SelW-1:0]  winner_o,
  output logic             any_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    found    = 1'b0;
    idx      = 0;
    winner_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr_i) + i) % N_REQ;
      if (!found && req_i[idx[SelW-1:0]]) begin
        found    = 1'b1;
        winner_o = idx[SelW-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/proc_arb_ctrl.sv
// Round-robin scheduler granting the shared proc datapath to one requester at a time,
// releasing on done or after a hold-limit timeout.
module proc_arb_ctrl import proc_arb_pkg::*; #(
  parameter int unsigned N_REQ    = PROC_N_REQ,
  parameter int unsigned MAX_HOLD = PROC_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     done_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] sel_o,
  output logic                     start_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned SelW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_HOLD);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_HOLD - 1);
  localparam logic [SelW-1:0] SelLast = SelW'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic [SelW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [SelW-1:0]  winner;
  logic             any_req;
  logic [SelW-1:0]  ptr_after;

  proc_rr_pick #(
    .N_REQ (N_REQ),
    .SelW  (SelW)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // Priority moves to the requester just after the one being released.
  assign ptr_after = (sel_q == SelLast) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          sel_d         = winner;
          start_d       = 1'b1;
          busy_d        = 1'b1;
          state_d       = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (done_i || (cnt_q == CntMax)) begin
          timeout_d = !done_i;
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = ptr_after;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign start_o   = start_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_proc_arb_ctrl.sv
// Directed bench for proc_arb_ctrl with default sizing (4 requesters, hold limit 8).
module tb_proc_arb_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       start;
  logic       busy;
  logic       timeout;

  int n_tests;
  int n_fail;
  int exp_order [5];
  logic prev_start;

  proc_arb_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .start_o   (start),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_start_busy", 32'(start && !busy), 32'd0);
      chk("inv_start_twice", 32'(start && prev_start), 32'd0);
      prev_start <= start;
    end else begin
      prev_start <= 1'b0;
    end
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_order  = '{0, 1, 2, 3, 0};
    rst_n      = 1'b0;
    req        = 4'b0000;
    done       = 1'b0;
    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester
    req = 4'b0100;
    cyc();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'(sel), 32'd2);
    chk("single_start", 32'(start), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    cyc();
    chk("single_start_low", 32'(start), 32'd0);
    chk("single_busy_hold", 32'(busy), 32'd1);
    cyc();
    chk("single_gnt_hold", 32'(gnt), 32'h4);
    done = 1'b1;
    req  = 4'b0000;
    cyc();
    done = 1'b0;
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_rel_busy", 32'(busy), 32'd0);
    chk("single_rel_tmo", 32'(timeout), 32'd0);
    chk("single_ptr", 32'(dut.ptr_q), 32'd3);

    // Rotation from a fresh pointer
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rot_gnt", 32'(gnt), 32'd1 << exp_order[i]);
      chk("rot_sel", 32'(sel), 32'(exp_order[i]));
      chk("rot_start", 32'(start), 32'd1);
      cyc();
      chk("rot_start_low", 32'(start), 32'd0);
      done = 1'b1;
      if (i == 4) req = 4'b0000;
      cyc();
      done = 1'b0;
      chk("rot_rel_gnt", 32'(gnt), 32'h0);
      chk("rot_idle_busy", 32'(busy), 32'd0);
    end
    chk("rot_ptr", 32'(dut.ptr_q), 32'd1);

    // Timeout: START plus MAX_HOLD BUSY cycles
    req = 4'b0001;
    cyc();
    chk("tmo_start", 32'(start), 32'd1);
    req = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("tmo_busy", 32'(busy), 32'd1);
      chk("tmo_early", 32'(timeout), 32'd0);
    end
    cyc();
    chk("tmo_rel_busy", 32'(busy), 32'd0);
    chk("tmo_rel_gnt", 32'(gnt), 32'h0);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    chk("tmo_ptr", 32'(dut.ptr_q), 32'd1);
    cyc();
    chk("tmo_pulse_end", 32'(timeout), 32'd0);

    // done coincides with the hold limit
    req = 4'b0001;
    cyc();
    req = 4'b0000;
    for (int i = 1; i <= 8; i++) cyc();
    chk("coin_busy_pre", 32'(busy), 32'd1);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("coin_busy", 32'(busy), 32'd0);
    chk("coin_tmo", 32'(timeout), 32'd0);
    chk("coin_gnt", 32'(gnt), 32'h0);

    // done in IDLE and in START ignored; req dropped mid-grant keeps the grant
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_tmo", 32'(timeout), 32'd0);
    req = 4'b0010;
    cyc();
    chk("ign_sel", 32'(sel), 32'd1);
    done = 1'b1;
    req  = 4'b0000;
    cyc();
    done = 1'b0;
    chk("ign_start_done_busy", 32'(busy), 32'd1);
    chk("ign_start_done_gnt", 32'(gnt), 32'h2);
    cyc();
    cyc();
    chk("ign_req_drop_gnt", 32'(gnt), 32'h2);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("ign_rel_gnt", 32'(gnt), 32'h0);
    chk("ign_ptr", 32'(dut.ptr_q), 32'd2);

    // Asynchronous reset mid-grant
    req = 4'b1000;
    cyc();
    chk("rstmid_sel", 32'(sel), 32'd3);
    req = 4'b0000;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_gnt", 32'(gnt), 32'h0);
    chk("rstmid_sel0", 32'(sel), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_start", 32'(start), 32'd0);
    chk("rstmid_tmo", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1001;
    cyc();
    chk("rstmid_next_gnt", 32'(gnt), 32'h1);
    chk("rstmid_next_sel", 32'(sel), 32'd0);
    req = 4'b0000;
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("rstmid_final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_arb_ctrl.md
# proc_arb_ctrl

Round-robin scheduler that shares the single `proc` datapath among `N_REQ` requesters. It grants one requester at a time and issues a one-cycle `start` to `proc`. It holds the grant until `proc` reports `done` or a hold-limit timer expires, then rotates priority. It sits between the requester agents and `proc`, and is the only block that drives the `proc` start and select lines.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, 8: maximum cycles a grant may remain in BUSY before forced release; legal range 2..255.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous assert, active-low; synchronous deassert is provided externally.
- `req` in N_REQ: level request per requester; sampled only in IDLE.
- `done` in 1: one-cycle completion pulse from `proc`.
- `gnt` out N_REQ: one-hot grant, registered; all zero when no grant is held.
- `sel` out $clog2(N_REQ): index of the granted requester; drives the `proc` operand mux; valid while `busy`=1.
- `start` out 1: one-cycle pulse to `proc`.
- `busy` out 1: high in START and BUSY.
- `timeout` out 1: one-cycle pulse on forced release.

## Operation
- The FSM has three states: IDLE, START, BUSY. The reset state is IDLE.
- IDLE:
  - If `req` is nonzero, pick the winner by round-robin search starting at `ptr`.
  - Load `gnt`/`sel`, assert `start`, and go to START.
  - If `req` is zero, stay in IDLE.
- START:
  - Deassert `start`, clear `cnt` to 0, and go to BUSY.
  - `done` is ignored in this state.
- BUSY:
  - If `done`=1: clear `gnt`, set `ptr` to winner+1 mod N_REQ, and go to IDLE.
  - Otherwise, if `cnt`==MAX_HOLD-1: pulse `timeout`, clear `gnt`, set `ptr` to winner+1 mod N_REQ, and go to IDLE.
  - Otherwise increment `cnt`.
  - When `done` and the limit coincide, `done` wins and there is no `timeout` pulse.
- `ptr` is $clog2(N_REQ) bits, reset to 0, and updates only on release.
- `cnt` is $clog2(MAX_HOLD) bits and saturates; it never wraps past MAX_HOLD-1.
- Dropping `req` during START/BUSY does not revoke the grant; release happens only via `done` or timeout.
- A new `req` arriving during BUSY waits for IDLE.
- `sel` holds its last value after release, but consumers must qualify it with `busy`.
- On reset mid-operation, every output clears immediately and asynchronously: `gnt`=0, `sel`=0, `start`=0, `busy`=0, `timeout`=0, and state=IDLE. No `done` is expected afterwards; a stray `done` seen in IDLE is ignored.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency:
  - `req` sampled at edge k → `gnt`, `sel`, `busy`, `start` high after edge k.
  - `start` is low after edge k+1.
- Release:
  - `done` sampled at edge m → `gnt`=0 and `busy`=0 after edge m.
  - The earliest next grant is after edge m+1, so there is at least one IDLE cycle between grants.
- Timeout: with no `done`, the grant lasts 1 (START) + MAX_HOLD (BUSY) cycles, and `timeout` is high for the final cycle after release.
- Invariants:
  - `gnt` is one-hot or zero.
  - `start` implies `busy`.
  - `start` is never asserted on two consecutive cycles.

## Structure
- Package `proc_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, BUSY} arb_state_t`
  - Default constants `PROC_N_REQ`=4 and `PROC_MAX_HOLD`=8.
- Sub-module `proc_rr_pick`: combinational rotate-priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `winner` index and `any`.
  - The FSM, counter, and output registers stay in `proc_arb_ctrl`.

## Test plan
- **Single requester:** reset, `req`=4'b0100 held, `done` pulsed 3 cycles after `start` → `gnt`=4'b0100, `sel`=2, one `start` pulse, release after `done`, `ptr`=3.
- **Rotation:** `req`=4'b1111 constant, `done` 2 cycles after each `start` → grant order 0,1,2,3,0 with one IDLE cycle between grants.
- **Timeout:** `req`=4'b0001, no `done`, MAX_HOLD=8 → `busy` high for 9 cycles, `timeout` pulses once, `gnt` cleared, `ptr`=1.
- **Simultaneous `done` and limit:** `done` asserted in the BUSY cycle with `cnt`=7 → clean release, `timeout`=0.
- **Ignored inputs:** `done` in START and `done` in IDLE are ignored; `req` dropped mid-BUSY → `gnt` held until `done`.
- **Reset mid-grant:** assert `rst_n`=0 in BUSY, off-edge → all outputs 0 immediately; after release the next grant starts from requester 0.
